// File: rtl/sfu_lut_interp_multi_pkg.sv
// Shared definitions for the SFU programmable LUT interpolator.
//   mode_e     : per-beat sign-symmetry mode (only x>=0 is stored in the table)
//   ACC_W      : width of the intermediate used by the clamp helper
//   sat_clamp  : saturate a wide signed value to a w-bit signed range
package sfu_lut_pkg;

  localparam int unsigned MODE_W = 2;
  localparam int unsigned ACC_W  = 64;

  typedef enum logic [MODE_W-1:0] {
    MODE_EVEN     = 2'd0,
    MODE_ODD      = 2'd1,
    MODE_ZERO_NEG = 2'd2,
    MODE_RSVD     = 2'd3   // treated as EVEN
  } mode_e;

  function automatic logic signed [ACC_W-1:0] sat_clamp(
    input logic signed [ACC_W-1:0] v,
    input int unsigned             w
  );
    logic signed [ACC_W-1:0] hi_lim;
    logic signed [ACC_W-1:0] lo_lim;
    hi_lim = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo_lim = -hi_lim - 64'sd1;
    if (v > hi_lim)      return hi_lim;
    else if (v < lo_lim) return lo_lim;
    return v;
  endfunction

endpackage

// File: rtl/sfu_lut_interp_multi_if.sv
// Stream bundle between the SFU input streamer, the LUT interpolator and the
// output writer.
//   in_valid/in_ready/in_data    : input beats, lane k at [k*IN_W +: IN_W]
//   out_valid/out_ready/out_data : output beats, lane k at [k*OUT_W +: OUT_W]
// master = the side that sources input beats and sinks output beats.
// slave  = the interpolator.
interface sfu_lut_interp_multi_if #(
  parameter int unsigned LANES = 4,
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*IN_W-1:0]  in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*OUT_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/sfu_lut_interp_multi_lane.sv
// One lane's back half of the interpolator: stage 2 (interpolate + clamp)
// and stage 3 (sign fix-up). Registers advance only when en=1.
//   clk, rst_n   : clock, async active-low reset
//   en           : pipeline advance
//   lo, hi, frac : stage-1 table pair and fraction
//   sign, mode   : stage-1 input sign and symmetry mode
//   y            : stage-3 lane output
module sfu_lut_lane
  import sfu_lut_pkg::*;
#(
  parameter int unsigned OUT_W     = 16,
  parameter int unsigned FRAC_BITS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic signed [OUT_W-1:0] lo,
  input  logic signed [OUT_W-1:0] hi,
  input  logic [FRAC_BITS-1:0]    frac,
  input  logic                    sign,
  input  mode_e                   mode,
  output logic signed [OUT_W-1:0] y
);

  localparam int unsigned PROD_W = OUT_W + FRAC_BITS + 2;

  logic signed [OUT_W:0]    diff;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] step;
  logic signed [PROD_W:0]   sum;
  logic signed [OUT_W-1:0]  y2_d;
  logic signed [OUT_W-1:0]  y2_q;
  logic                     sign2_q;
  mode_e                    mode2_q;
  logic signed [OUT_W:0]    neg_ext;
  logic signed [OUT_W-1:0]  neg_sat;
  logic signed [OUT_W-1:0]  y3_d;

  // Stage 2: lo + floor(diff*frac / 2^FRAC_BITS), then saturate.
  always_comb begin
    diff = {hi[OUT_W-1], hi} - {lo[OUT_W-1], lo};
    prod = PROD_W'(diff) * PROD_W'($signed({1'b0, frac}));
    step = prod >>> FRAC_BITS;
    sum  = (PROD_W+1)'(lo) + (PROD_W+1)'(step);
    y2_d = OUT_W'(sat_clamp(64'(sum), OUT_W));
  end

  // Stage 3: negating the most negative value saturates to the max.
  always_comb begin
    neg_ext = -((OUT_W+1)'(y2_q));
    neg_sat = OUT_W'(sat_clamp(64'(neg_ext), OUT_W));
    y3_d    = y2_q;
    if (sign2_q) begin
      case (mode2_q)
        MODE_ODD:      y3_d = neg_sat;
        MODE_ZERO_NEG: y3_d = '0;
        default:       y3_d = y2_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y2_q    <= '0;
      sign2_q <= 1'b0;
      mode2_q <= MODE_EVEN;
      y       <= '0;
    end else if (en) begin
      y2_q    <= y2_d;
      sign2_q <= sign;
      mode2_q <= mode;
      y       <= y3_d;
    end
  end

endmodule

// File: rtl/sfu_lut_interp_multi.sv
// Multi-lane runtime-programmable activation unit. A software-loaded table of
// DEPTH signed entries (x>=0 half only) is shared by LANES lanes; each lane
// interpolates linearly between adjacent entries and applies a symmetry mode
// for negative inputs. 3-stage valid/ready pipeline, all stages stall together.
//   clk, rst_n          : clock, async active-low reset
//   cfg_we/addr/data    : table write port (addr >= DEPTH ignored)
//   cfg_mode            : symmetry mode, captured with each accepted beat
//   bus (slave)         : input/output beat streams
//   busy                : any stage holds a valid beat
module sfu_lut_interp_multi
  import sfu_lut_pkg::*;
#(
  parameter int unsigned LANES     = 4,
  parameter int unsigned IN_W      = 16,
  parameter int unsigned FRAC_BITS = 8,
  parameter int unsigned OUT_W     = 16,
  parameter int unsigned ADDR_W    = 7,
  parameter int unsigned DEPTH     = 96
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_we,
  input  logic [ADDR_W-1:0]       cfg_addr,
  input  logic signed [OUT_W-1:0] cfg_data,
  input  logic [1:0]              cfg_mode,
  sfu_lut_interp_multi_if.slave   bus,
  output logic                    busy
);

  localparam int unsigned IDX_W = IN_W - FRAC_BITS;

  logic signed [OUT_W-1:0] tbl [DEPTH];

  logic advance;
  logic v1, v2, v3;

  logic signed [OUT_W-1:0] lo_d   [LANES];
  logic signed [OUT_W-1:0] hi_d   [LANES];
  logic [FRAC_BITS-1:0]    frac_d [LANES];
  logic                    sign_d [LANES];

  logic signed [OUT_W-1:0] lo_q   [LANES];
  logic signed [OUT_W-1:0] hi_q   [LANES];
  logic [FRAC_BITS-1:0]    frac_q [LANES];
  logic                    sign_q [LANES];
  mode_e                   mode_q;

  logic signed [OUT_W-1:0] y_lane [LANES];

  assign advance      = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = advance;
  assign bus.out_valid = v3;
  assign busy         = v1 || v2 || v3;

  // Table register file. A beat accepted on a write edge has already sampled
  // the combinational read below, so it sees the old entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) tbl[i] <= '0;
    end else if (cfg_we && (32'(cfg_addr) < DEPTH)) begin
      tbl[cfg_addr] <= cfg_data;
    end
  end

  // Stage 1 front end: magnitude, index/fraction split, table pair read.
  always_comb begin
    logic [IN_W-1:0]   x;
    logic [IN_W-1:0]   mag;
    logic [IDX_W-1:0]  idx;
    logic [ADDR_W-1:0] addr;
    for (int unsigned k = 0; k < LANES; k++) begin
      x         = bus.in_data[k*IN_W +: IN_W];
      mag       = x[IN_W-1] ? (~x + 1'b1) : x;
      idx       = mag[IN_W-1:FRAC_BITS];
      addr      = ADDR_W'(idx);
      sign_d[k] = x[IN_W-1];
      lo_d[k]   = tbl[DEPTH-1];
      hi_d[k]   = tbl[DEPTH-1];
      frac_d[k] = '0;
      if (32'(idx) < DEPTH - 1) begin
        lo_d[k]   = tbl[addr];
        hi_d[k]   = tbl[addr + 1'b1];
        frac_d[k] = mag[FRAC_BITS-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      v3     <= 1'b0;
      mode_q <= MODE_EVEN;
      for (int unsigned k = 0; k < LANES; k++) begin
        lo_q[k]   <= '0;
        hi_q[k]   <= '0;
        frac_q[k] <= '0;
        sign_q[k] <= 1'b0;
      end
    end else if (advance) begin
      v1     <= bus.in_valid;
      v2     <= v1;
      v3     <= v2;
      mode_q <= mode_e'(cfg_mode);
      for (int unsigned k = 0; k < LANES; k++) begin
        lo_q[k]   <= lo_d[k];
        hi_q[k]   <= hi_d[k];
        frac_q[k] <= frac_d[k];
        sign_q[k] <= sign_d[k];
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    sfu_lut_lane #(
      .OUT_W     (OUT_W),
      .FRAC_BITS (FRAC_BITS)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (advance),
      .lo    (lo_q[k]),
      .hi    (hi_q[k]),
      .frac  (frac_q[k]),
      .sign  (sign_q[k]),
      .mode  (mode_q),
      .y     (y_lane[k])
    );
  end

  always_comb begin
    bus.out_data = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      bus.out_data[k*OUT_W +: OUT_W] = y_lane[k];
    end
  end

endmodule

// File: tb/tb_sfu_lut_interp_multi.sv
// Scoreboard bench for sfu_lut_interp_multi: the driver pushes expected output
// beats when a beat is accepted, a monitor pops and compares on each output
// transfer and checks that a stalled output holds.
module tb_sfu_lut_interp_multi;

  localparam int LANES = 4;
  localparam int DEPTH = 96;

  logic clk;
  logic rst_n;
  logic cfg_we;
  logic [6:0] cfg_addr;
  logic signed [15:0] cfg_data;
  logic [1:0] cfg_mode;
  logic busy;

  sfu_lut_interp_multi_if #(.LANES(4), .IN_W(16), .OUT_W(16)) bus ();

  sfu_lut_interp_multi #(
    .LANES(4), .IN_W(16), .FRAC_BITS(8), .OUT_W(16), .ADDR_W(7), .DEPTH(96)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .cfg_mode (cfg_mode),
    .bus      (bus),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];
  int tmod [DEPTH];
  logic stall_prev = 1'b0;
  logic [63:0] prev_data;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  function automatic int clamp16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // f(x) from the table model: piecewise-linear on |x|, floor of the
  // fractional step, then the symmetry mode for negative x.
  function automatic int ref_lane(input int x, input int md);
    int mag, idx, frac, lo, hi, p, q, y;
    bit s;
    s    = (x < 0);
    mag  = s ? -x : x;
    idx  = mag / 256;
    frac = mag % 256;
    if (idx >= DEPTH - 1) begin
      lo = tmod[DEPTH-1]; hi = lo; frac = 0;
    end else begin
      lo = tmod[idx]; hi = tmod[idx+1];
    end
    p = (hi - lo) * frac;
    q = p / 256;
    if (p < 0 && (p % 256) != 0) q = q - 1;
    y = clamp16(lo + q);
    if (s) begin
      if (md == 1) y = clamp16(-y);
      else if (md == 2) y = 0;
    end
    return y;
  endfunction

  function automatic logic [63:0] ref_vec(input logic [63:0] xv, input int md);
    logic [63:0] ev;
    logic signed [15:0] xs;
    int y;
    ev = '0;
    for (int k = 0; k < LANES; k++) begin
      xs = xv[k*16 +: 16];
      y  = ref_lane(int'(xs), md);
      ev[k*16 +: 16] = y[15:0];
    end
    return ev;
  endfunction

  function automatic logic [63:0] rep4(input logic [15:0] v);
    return {v, v, v, v};
  endfunction

  // One clock of stimulus. Expectation is taken before the same-edge table
  // write is applied to the model, matching read-old-on-collision.
  task automatic cycle(input logic we, input int addr, input int data,
                       input logic vld, input logic [63:0] xv, input int md,
                       input logic ordy, input logic use_model,
                       input logic [63:0] expv, output logic acc);
    logic signed [15:0] d16;
    @(negedge clk);
    cfg_we        = we;
    cfg_addr      = addr[6:0];
    cfg_data      = data[15:0];
    cfg_mode      = md[1:0];
    bus.in_valid  = vld;
    bus.in_data   = xv;
    bus.out_ready = ordy;
    #1;
    acc = vld && bus.in_ready;
    if (acc) exp_q.push_back(use_model ? ref_vec(xv, md) : expv);
    if (we && addr < DEPTH) begin
      d16 = data[15:0];
      tmod[addr] = int'(d16);
    end
    @(posedge clk);
  endtask

  task automatic idle(input logic ordy);
    logic a;
    cycle(1'b0, 0, 0, 1'b0, 64'h0, 0, ordy, 1'b1, 64'h0, a);
  endtask

  task automatic wr(input int addr, input int data);
    logic a;
    cycle(1'b1, addr, data, 1'b0, 64'h0, 0, 1'b1, 1'b1, 64'h0, a);
  endtask

  task automatic beat(input logic [63:0] xv, input int md, input logic [63:0] expv);
    logic a;
    cycle(1'b0, 0, 0, 1'b1, xv, md, 1'b1, 1'b0, expv, a);
    if (!a) begin
      n_cmp++; n_err++;
      $display("FAIL beat_accept: got in_ready 0 expected 1");
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 50) begin
      idle(1'b1);
      n++;
    end
    #1;
    chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_busy"}, 64'(busy), 64'd0);
  endtask

  // Monitor: sample well after the driver's negedge updates, before posedge.
  always begin
    @(negedge clk);
    #2;
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", 64'(bus.out_valid), 64'd1);
        chk("stall_data", bus.out_data, prev_data);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_out: got %h expected no beat", bus.out_data);
        end else begin
          chk("out_data", bus.out_data, exp_q.pop_front());
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
    end
  end

  initial begin
    logic acc;
    logic [63:0] xs [5];
    int sent, n;

    for (int i = 0; i < DEPTH; i++) tmod[i] = 0;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_mode = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", bus.out_data, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Interpolation and latency
    wr(1, 16'h0661);
    wr(2, 16'h098F);
    beat({16'h0, 16'h0, 16'h0, 16'h0180}, 0, {16'h0, 16'h0, 16'h0, 16'h07F8});
    idle(1'b1);
    #1 chk("lat_n1_valid", 64'(bus.out_valid), 64'd0);
    idle(1'b1);
    #1 chk("lat_n2_valid", 64'(bus.out_valid), 64'd1);
    beat(rep4(16'h0180), 0, rep4(16'h07F8));

    // Symmetry modes
    beat(rep4(16'hFE80), 1, rep4(16'hF808));
    beat(rep4(16'hFE80), 0, rep4(16'h07F8));
    beat(rep4(16'hFE80), 2, rep4(16'h0000));
    beat(rep4(16'hFE80), 3, rep4(16'h07F8));
    drain("sym");

    // Saturation and ignored write
    wr(95, 16'h7FFD);
    beat(rep4(16'h7FFF), 0, rep4(16'h7FFD));
    beat(rep4(16'h8000), 1, rep4(16'h8003));
    beat(rep4(16'h5F00), 0, rep4(16'h7FFD));
    wr(0, 16'h0330);
    wr(96, 16'h1234);
    beat(rep4(16'h0000), 0, rep4(16'h0330));
    beat(rep4(16'h0000), 1, rep4(16'h0330));
    beat(rep4(16'h0000), 2, rep4(16'h0330));
    drain("sat");

    // Backpressure: 6 stalled cycles offering 5 beats
    xs[0] = rep4(16'h0180); xs[1] = rep4(16'h0100); xs[2] = rep4(16'h0200);
    xs[3] = {16'hFE80, 16'h0180, 16'h0040, 16'h8000}; xs[4] = rep4(16'h0040);
    sent = 0;
    for (int c = 0; c < 6; c++) begin
      cycle(1'b0, 0, 0, sent < 5, (sent < 5) ? xs[sent] : 64'h0, 1, 1'b0, 1'b1, 64'h0, acc);
      if (acc) sent++;
    end
    #1;
    chk("bp_accepted", 64'(sent), 64'd3);
    chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    n = 0;
    while (sent < 5 && n < 20) begin
      cycle(1'b0, 0, 0, 1'b1, xs[sent], 1, 1'b1, 1'b1, 64'h0, acc);
      if (acc) sent++;
      n++;
    end
    chk("bp_all_sent", 64'(sent), 64'd5);
    drain("bp");

    // Write collision: same-edge beat reads the old entry
    cycle(1'b1, 1, 16'h1000, 1'b1, rep4(16'h0100), 0, 1'b1, 1'b0, rep4(16'h0661), acc);
    chk("coll_accept", 64'(acc), 64'd1);
    beat(rep4(16'h0100), 0, rep4(16'h1000));
    drain("coll");

    // Randomized traffic with table rewrites, stalls and bubbles
    for (int c = 0; c < 600; c++) begin
      logic we, vld, ordy;
      we   = ($urandom_range(0, 7) == 0);
      vld  = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      cycle(we, int'($urandom_range(0, 127)), int'($urandom_range(0, 65535)),
            vld, {$urandom, $urandom}, int'($urandom_range(0, 3)), ordy, 1'b1, 64'h0, acc);
    end
    drain("rand");

    // Reset with beats in flight
    beat(rep4(16'h0180), 0, rep4(16'h07F8));
    beat(rep4(16'h0100), 0, rep4(16'h07F8));
    beat(rep4(16'h0200), 0, rep4(16'h07F8));
    #1 chk("pre_rst_busy", 64'(busy), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) tmod[i] = 0;
    #1;
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_out_data", bus.out_data, 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    beat(rep4(16'h0100), 0, rep4(16'h0000));
    drain("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
